// File: rtl/ddr_sched_pkg.sv
// Shared state, command encodings and sizing helper for the DFI command scheduler.
package ddr_sched_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_ACT,
    ST_WAIT_RCD,
    ST_COL,
    ST_WAIT_DONE,
    ST_PRE,
    ST_WAIT_RP
  } state_t;

  // {cs_n, ras_n, cas_n, we_n}
  typedef logic [3:0] cmd_t;

  localparam cmd_t CMD_DES = 4'b1111;
  localparam cmd_t CMD_NOP = 4'b0111;
  localparam cmd_t CMD_ACT = 4'b0011;
  localparam cmd_t CMD_RD  = 4'b0101;
  localparam cmd_t CMD_WR  = 4'b0100;
  localparam cmd_t CMD_PRE = 4'b0010;

  // Counter width able to hold max_val, never narrower than one bit.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/dfi_latency_pipe.sv
// Turns a one-cycle pulse into a registered LEN-cycle window; the window's first
// cycle is LAT cycles after the first cycle the pulse was registered.
module dfi_latency_pipe
  import ddr_sched_pkg::*;
#(
  parameter int LAT = 4,
  parameter int LEN = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pulse,
  output logic window
);

  localparam int CW = cnt_w(LEN - 1);

  logic          start;
  logic [CW-1:0] len_cnt;

  generate
    if (LAT == 0) begin : g_nodly
      assign start = pulse;
    end else begin : g_dly
      logic [LAT-1:0] dly;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) dly <= '0;
        else     dly <= (dly << 1) | LAT'(pulse);
      end
      assign start = dly[LAT-1];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      window  <= 1'b0;
      len_cnt <= '0;
    end else if (start) begin
      window  <= 1'b1;
      len_cnt <= CW'(LEN - 1);
    end else if (len_cnt != '0) begin
      window  <= 1'b1;
      len_cnt <= len_cnt - CW'(1);
    end else begin
      window  <= 1'b0;
    end
  end

endmodule

// File: rtl/ddr_cmd_scheduler.sv
// Close-page single-access DFI command sequencer: CKE power-up, then ACT -> RD/WR -> PRE
// per request with tRCD/tRAS/tWR/tRP spacing and WL/RL-aligned data enables.
//
//   state        | meaning
//   ST_INIT      | CKE low, deselect, counting T_INIT
//   ST_IDLE      | req_ready high, waiting for a request
//   ST_ACT       | ACT on the bus
//   ST_WAIT_RCD  | NOPs until tRCD met
//   ST_COL       | RD or WR on the bus
//   ST_WAIT_DONE | NOPs until tRAS and data/recovery done
//   ST_PRE       | PRE on the bus
//   ST_WAIT_RP   | NOPs until tRP met
module ddr_cmd_scheduler
  import ddr_sched_pkg::*;
#(
  parameter int BA_W      = 3,
  parameter int ADDR_W    = 14,
  parameter int T_INIT    = 16,
  parameter int T_RCD     = 3,
  parameter int T_RAS     = 8,
  parameter int T_WR      = 4,
  parameter int T_RP      = 3,
  parameter int WL        = 4,
  parameter int RL        = 5,
  parameter int BURST_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [BA_W-1:0]   req_ba,
  input  logic [ADDR_W-1:0] req_row,
  input  logic [ADDR_W-1:0] req_col,
  output logic              dfi_cke,
  output logic              dfi_cs_n,
  output logic              dfi_ras_n,
  output logic              dfi_cas_n,
  output logic              dfi_we_n,
  output logic [BA_W-1:0]   dfi_ba,
  output logic [ADDR_W-1:0] dfi_addr,
  output logic              dfi_odt,
  output logic              dfi_wrdata_en,
  output logic              dfi_rddata_en
);

  localparam int REC_WR   = WL + BURST_CYC + T_WR;
  localparam int WAIT_MAX = (T_RCD > T_RP) ? T_RCD : T_RP;
  localparam int INIT_W   = cnt_w(T_INIT);
  localparam int RAS_W    = cnt_w(T_RAS);
  localparam int REC_W    = cnt_w(REC_WR);
  localparam int WAIT_W   = cnt_w(WAIT_MAX);
  localparam int ODT_W    = cnt_w(WL + BURST_CYC - 1);

  state_t              state, state_nxt;
  logic [INIT_W-1:0]   init_cnt;
  logic [RAS_W-1:0]    tras_cnt, tras_dec;
  logic [REC_W-1:0]    rec_cnt, rec_dec;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [ODT_W-1:0]    odt_cnt;
  logic                lat_wr;
  logic [BA_W-1:0]     lat_ba;
  logic [ADDR_W-1:0]   lat_col;
  logic                accept, wr_fire, rd_fire;
  cmd_t                cmd_nxt;
  logic [BA_W-1:0]     ba_nxt;
  logic [ADDR_W-1:0]   addr_nxt;

  assign accept   = (state == ST_IDLE) && req_valid;
  assign tras_dec = (tras_cnt == '0) ? '0 : tras_cnt - RAS_W'(1);
  assign rec_dec  = (rec_cnt == '0) ? '0 : rec_cnt - REC_W'(1);
  assign wr_fire  = (state_nxt == ST_COL) && lat_wr;
  assign rd_fire  = (state_nxt == ST_COL) && !lat_wr;

  // wait_cnt holds the remaining tRCD/tRP distance; the cycle where it would reach 0 starts the next phase.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT:                  if (init_cnt == '0) state_nxt = ST_IDLE;
      ST_IDLE:                  if (req_valid) state_nxt = ST_ACT;
      ST_ACT, ST_WAIT_RCD:      state_nxt = (wait_cnt == WAIT_W'(1)) ? ST_COL : ST_WAIT_RCD;
      ST_COL, ST_WAIT_DONE:     state_nxt = (tras_dec == '0 && rec_dec == '0) ? ST_PRE : ST_WAIT_DONE;
      ST_PRE, ST_WAIT_RP:       state_nxt = (wait_cnt == WAIT_W'(1)) ? ST_IDLE : ST_WAIT_RP;
      default:                  state_nxt = ST_INIT;
    endcase
  end

  always_comb begin
    cmd_nxt  = CMD_NOP;
    ba_nxt   = dfi_ba;
    addr_nxt = dfi_addr;
    case (state_nxt)
      ST_INIT: cmd_nxt = CMD_DES;
      ST_ACT: begin
        cmd_nxt  = CMD_ACT;
        ba_nxt   = req_ba;
        addr_nxt = req_row;
      end
      ST_COL: begin
        cmd_nxt  = lat_wr ? CMD_WR : CMD_RD;
        ba_nxt   = lat_ba;
        addr_nxt = lat_col;
      end
      ST_PRE: begin
        cmd_nxt  = CMD_PRE;
        ba_nxt   = lat_ba;
        addr_nxt = '0;
      end
      default: cmd_nxt = CMD_NOP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_INIT;
      init_cnt  <= INIT_W'(T_INIT);
      tras_cnt  <= '0;
      rec_cnt   <= '0;
      wait_cnt  <= '0;
      odt_cnt   <= '0;
      lat_wr    <= 1'b0;
      lat_ba    <= '0;
      lat_col   <= '0;
      req_ready <= 1'b0;
      dfi_cke   <= 1'b0;
      {dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n} <= CMD_DES;
      dfi_ba    <= '0;
      dfi_addr  <= '0;
      dfi_odt   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_INIT && init_cnt != '0) init_cnt <= init_cnt - INIT_W'(1);

      tras_cnt <= accept ? RAS_W'(T_RAS) : tras_dec;
      if (state_nxt == ST_COL) rec_cnt <= lat_wr ? REC_W'(REC_WR) : REC_W'(BURST_CYC);
      else                     rec_cnt <= rec_dec;

      if (accept)                   wait_cnt <= WAIT_W'(T_RCD);
      else if (state_nxt == ST_PRE) wait_cnt <= WAIT_W'(T_RP);
      else if (wait_cnt != '0)      wait_cnt <= wait_cnt - WAIT_W'(1);

      if (accept) begin
        lat_wr  <= req_wr;
        lat_ba  <= req_ba;
        lat_col <= req_col;
      end

      req_ready <= (state_nxt == ST_IDLE);
      dfi_cke   <= (state_nxt != ST_INIT);
      {dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n} <= cmd_nxt;
      dfi_ba    <= ba_nxt;
      dfi_addr  <= addr_nxt;

      // ODT spans the WR cycle through the last write-data cycle.
      if (wr_fire) begin
        dfi_odt <= 1'b1;
        odt_cnt <= ODT_W'(WL + BURST_CYC - 1);
      end else if (odt_cnt != '0) begin
        dfi_odt <= 1'b1;
        odt_cnt <= odt_cnt - ODT_W'(1);
      end else begin
        dfi_odt <= 1'b0;
      end
    end
  end

  dfi_latency_pipe #(.LAT(WL), .LEN(BURST_CYC)) u_wr_pipe (
    .clk    (clk),
    .rst    (rst),
    .pulse  (wr_fire),
    .window (dfi_wrdata_en)
  );

  dfi_latency_pipe #(.LAT(RL), .LEN(BURST_CYC)) u_rd_pipe (
    .clk    (clk),
    .rst    (rst),
    .pulse  (rd_fire),
    .window (dfi_rddata_en)
  );

endmodule

// File: tb/tb_ddr_cmd_scheduler.sv
// Bench for ddr_cmd_scheduler: default build plus a fast-timing build, checked against
// event times computed from the timing parameters.
module tb_ddr_cmd_scheduler;

  localparam int T_INIT = 16, T_RCD = 3, T_RAS = 8, T_WR = 4, T_RP = 3, WL = 4, RL = 5, BC = 2;
  localparam int F_RCD = 1, F_WR = 0, F_BC = 1;
  localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, RD = 4'b0101, WR = 4'b0100, PRE = 4'b0010;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        req_valid, req_ready, req_wr;
  logic [2:0]  req_ba;
  logic [13:0] req_row, req_col;
  logic        dfi_cke, dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n, dfi_odt, dfi_wrdata_en, dfi_rddata_en;
  logic [2:0]  dfi_ba;
  logic [13:0] dfi_addr;

  logic        f_valid, f_ready, f_wr;
  logic [2:0]  f_ba;
  logic [13:0] f_row, f_col;
  logic        f_cke, f_cs_n, f_ras_n, f_cas_n, f_we_n, f_odt, f_wr_en, f_rd_en;
  logic [2:0]  f_dba;
  logic [13:0] f_addr;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ddr_cmd_scheduler dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_ba(req_ba), .req_row(req_row), .req_col(req_col), .dfi_cke(dfi_cke),
    .dfi_cs_n(dfi_cs_n), .dfi_ras_n(dfi_ras_n), .dfi_cas_n(dfi_cas_n), .dfi_we_n(dfi_we_n),
    .dfi_ba(dfi_ba), .dfi_addr(dfi_addr), .dfi_odt(dfi_odt),
    .dfi_wrdata_en(dfi_wrdata_en), .dfi_rddata_en(dfi_rddata_en)
  );

  ddr_cmd_scheduler #(.T_RCD(F_RCD), .T_WR(F_WR), .BURST_CYC(F_BC)) dut_fast (
    .clk(clk), .rst(rst), .req_valid(f_valid), .req_ready(f_ready), .req_wr(f_wr),
    .req_ba(f_ba), .req_row(f_row), .req_col(f_col), .dfi_cke(f_cke),
    .dfi_cs_n(f_cs_n), .dfi_ras_n(f_ras_n), .dfi_cas_n(f_cas_n), .dfi_we_n(f_we_n),
    .dfi_ba(f_dba), .dfi_addr(f_addr), .dfi_odt(f_odt),
    .dfi_wrdata_en(f_wr_en), .dfi_rddata_en(f_rd_en)
  );

  // Holds rst for a cycle, releases it at a negedge, then checks the INIT window cycle by cycle.
  task automatic test_reset();
    logic [3:0] cmd;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({dfi_cke, dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n, dfi_odt, dfi_wrdata_en, dfi_rddata_en, req_ready} !== 9'b0_1111_0000
        || dfi_ba !== 3'd0 || dfi_addr !== 14'd0)
      begin errors++; $display("FAIL reset_values: cke=%b cmd=%b%b%b%b odt=%b wen=%b ren=%b rdy=%b ba=%0d addr=%0h, required cke=0 cmd=1111 rest 0",
        dfi_cke, dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n, dfi_odt, dfi_wrdata_en, dfi_rddata_en, req_ready, dfi_ba, dfi_addr); end
    rst = 1'b0;
    for (int k = 0; k <= T_INIT; k++) begin
      @(negedge clk);
      cmd = {dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n};
      checks++;
      if (k < T_INIT) begin
        if (dfi_cke !== 1'b0 || dfi_cs_n !== 1'b1 || req_ready !== 1'b0)
          begin errors++; $display("FAIL init_cycle_%0d: cke=%b cs_n=%b rdy=%b, required 0 1 0", k, dfi_cke, dfi_cs_n, req_ready); end
      end else begin
        if (dfi_cke !== 1'b1 || cmd !== NOP || req_ready !== 1'b1)
          begin errors++; $display("FAIL init_done_%0d: cke=%b cmd=%b rdy=%b, required 1 0111 1", k, dfi_cke, cmd, req_ready); end
      end
    end
  endtask

  // Issues one request on the default build and checks every cycle up to req_ready returning.
  // mode 0: valid low while busy; 1: valid held high with junk fields; 2: random valid and junk.
  task automatic run_req(input logic wr, input logic [2:0] b, input logic [13:0] row, input logic [13:0] col,
                         input int mode, output int a_cyc, output int pre_obs, output int rdy_obs);
    int act, colc, rec, pre, rdy, guard;
    logic [3:0] cmd, exp_cmd;
    logic exp_wr, exp_rd, exp_odt, exp_rdy;
    a_cyc = -1; pre_obs = -1; rdy_obs = -1; guard = 0;
    while (req_ready !== 1'b1 && guard < 64) begin @(negedge clk); guard++; end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL ready_timeout: req_ready=%b after %0d cycles, required 1", req_ready, guard);
      return;
    end
    a_cyc = cyc;
    req_valid = 1'b1; req_wr = wr; req_ba = b; req_row = row; req_col = col;
    act  = a_cyc + 1;
    colc = act + T_RCD;
    rec  = wr ? (WL + BC + T_WR) : BC;
    pre  = (act + T_RAS > colc + rec) ? act + T_RAS : colc + rec;
    rdy  = pre + T_RP;
    for (int c = a_cyc + 1; c <= rdy; c++) begin
      @(negedge clk);
      if (c == rdy || mode == 0) req_valid = 1'b0;
      else if (mode == 1)        req_valid = 1'b1;
      else                       req_valid = 1'($urandom_range(0, 1));
      if (mode != 0) begin
        req_wr = 1'($urandom_range(0, 1)); req_ba = 3'($urandom_range(0, 7));
        req_row = 14'($urandom); req_col = 14'($urandom);
      end
      cmd = {dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n};
      exp_cmd = NOP;
      if (c == act)  exp_cmd = ACT;
      if (c == colc) exp_cmd = wr ? WR : RD;
      if (c == pre)  exp_cmd = PRE;
      if (cmd === PRE && pre_obs < 0) pre_obs = c;
      if (req_ready === 1'b1 && rdy_obs < 0) rdy_obs = c;
      checks++;
      if (cmd !== exp_cmd)
        begin errors++; $display("FAIL cmd@A+%0d: got %b, required %b (wr=%b)", c - a_cyc, cmd, exp_cmd, wr); end
      if (c == act || c == colc || c == pre) begin
        checks++;
        if (dfi_ba !== b || (c == act && dfi_addr !== row) || (c == colc && dfi_addr !== col) || (c == pre && dfi_addr[10] !== 1'b0))
          begin errors++; $display("FAIL addr@A+%0d: ba=%0d addr=%0h, required ba=%0d row=%0h col=%0h", c - a_cyc, dfi_ba, dfi_addr, b, row, col); end
      end
      exp_wr  = wr  && c >= colc + WL && c < colc + WL + BC;
      exp_rd  = !wr && c >= colc + RL && c < colc + RL + BC;
      exp_odt = wr  && c >= colc && c < colc + WL + BC;
      exp_rdy = (c == rdy);
      checks++;
      if ({dfi_wrdata_en, dfi_rddata_en, dfi_odt, req_ready, dfi_cke} !== {exp_wr, exp_rd, exp_odt, exp_rdy, 1'b1})
        begin errors++; $display("FAIL ctl@A+%0d: wen/ren/odt/rdy/cke=%b%b%b%b%b, required %b%b%b%b1",
          c - a_cyc, dfi_wrdata_en, dfi_rddata_en, dfi_odt, req_ready, dfi_cke, exp_wr, exp_rd, exp_odt, exp_rdy); end
    end
  endtask

  task automatic test_read();
    int a, p, r;
    run_req(1'b0, 3'd2, 14'h155, 14'h020, 0, a, p, r);
    checks++;
    if (p - a != 9 || r - a != 12)
      begin errors++; $display("FAIL read_timing: PRE@A+%0d ready@A+%0d, required A+9 A+12", p - a, r - a); end
  endtask

  task automatic test_write();
    int a, p, r;
    run_req(1'b1, 3'd5, 14'h003, 14'h008, 0, a, p, r);
    checks++;
    if (p - a != 14 || r - a != 17)
      begin errors++; $display("FAIL write_timing: PRE@A+%0d ready@A+%0d, required A+14 A+17", p - a, r - a); end
  endtask

  task automatic test_back_to_back();
    int a1, p1, r1, a2, p2, r2;
    run_req(1'b1, 3'd1, 14'h0aa, 14'h010, 1, a1, p1, r1);
    run_req(1'b0, 3'd6, 14'h3ff, 14'h018, 1, a2, p2, r2);
    checks++;
    if (a2 != r1 || (a2 + 1) - p1 != T_RP + 1)
      begin errors++; $display("FAIL back_to_back: accept2-ready1=%0d ACT2-PRE1=%0d, required 0 and %0d", a2 - r1, a2 + 1 - p1, T_RP + 1); end
  endtask

  task automatic test_random();
    int a, p, r;
    for (int i = 0; i < 16; i++)
      run_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 14'($urandom), 14'($urandom), 2, a, p, r);
  endtask

  task automatic test_rst_mid();
    int a, p, r, g;
    g = 0;
    while (req_ready !== 1'b1 && g < 64) begin @(negedge clk); g++; end
    req_valid = 1'b1; req_wr = 1'b1; req_ba = 3'd3; req_row = 14'h077; req_col = 14'h004;
    @(negedge clk);
    req_valid = 1'b0;
    g = 0;
    while (dfi_wrdata_en !== 1'b1 && g < 20) begin @(negedge clk); g++; end
    checks++;
    if (dfi_wrdata_en !== 1'b1)
      begin errors++; $display("FAIL rst_mid_wait: wrdata_en=%b after %0d cycles, required 1", dfi_wrdata_en, g); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({dfi_cke, dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n, dfi_odt, dfi_wrdata_en, dfi_rddata_en, req_ready} !== 9'b0_1111_0000
        || dfi_ba !== 3'd0 || dfi_addr !== 14'd0)
      begin errors++; $display("FAIL rst_mid_immediate: cke=%b cmd=%b%b%b%b odt=%b wen=%b ren=%b rdy=%b ba=%0d addr=%0h, required reset values",
        dfi_cke, dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n, dfi_odt, dfi_wrdata_en, dfi_rddata_en, req_ready, dfi_ba, dfi_addr); end
    test_reset();
    run_req(1'b0, 3'd4, 14'h123, 14'h03c, 0, a, p, r);
  endtask

  task automatic test_fast_build();
    int a, g, act_o, col_o, pre_o, en_first, en_cnt, odt_first, odt_cnt, rdy_o, e_col, e_pre, e_en, e_rdy, c;
    logic [3:0] cmd;
    for (int op = 0; op < 2; op++) begin
      act_o = -1; col_o = -1; pre_o = -1; en_first = -1; en_cnt = 0; odt_first = -1; odt_cnt = 0; rdy_o = -1; g = 0;
      while (f_ready !== 1'b1 && g < 64) begin @(negedge clk); g++; end
      checks++;
      if (f_ready !== 1'b1) begin errors++; $display("FAIL fast_ready_timeout: ready=%b, required 1", f_ready); end
      a = cyc;
      f_valid = 1'b1; f_wr = op[0]; f_ba = 3'd7; f_row = 14'h2a5; f_col = 14'h00c;
      for (int k = 1; k <= 16; k++) begin
        @(negedge clk);
        f_valid = 1'b0;
        c = a + k;
        cmd = {f_cs_n, f_ras_n, f_cas_n, f_we_n};
        if (cmd === ACT && act_o < 0) act_o = c;
        if (cmd === (op[0] ? WR : RD) && col_o < 0) col_o = c;
        if (cmd === PRE && pre_o < 0) pre_o = c;
        if ((op[0] ? f_wr_en : f_rd_en) === 1'b1) begin if (en_first < 0) en_first = c; en_cnt++; end
        if (f_odt === 1'b1) begin if (odt_first < 0) odt_first = c; odt_cnt++; end
        if (f_ready === 1'b1 && rdy_o < 0) rdy_o = c;
      end
      e_col = a + 1 + F_RCD;
      e_pre = (a + 1 + T_RAS > e_col + (op[0] ? WL + F_BC + F_WR : F_BC)) ? a + 1 + T_RAS : e_col + (op[0] ? WL + F_BC + F_WR : F_BC);
      e_en  = e_col + (op[0] ? WL : RL);
      e_rdy = e_pre + T_RP;
      checks++;
      if (act_o != a + 1 || col_o != e_col)
        begin errors++; $display("FAIL fast_act_col op=%0d: ACT@A+%0d COL@A+%0d, required A+1 A+%0d", op, act_o - a, col_o - a, e_col - a); end
      checks++;
      if (en_first != e_en || en_cnt != F_BC)
        begin errors++; $display("FAIL fast_data_en op=%0d: first@A+%0d len=%0d, required A+%0d len %0d", op, en_first - a, en_cnt, e_en - a, F_BC); end
      checks++;
      if (pre_o != e_pre || rdy_o != e_rdy)
        begin errors++; $display("FAIL fast_pre op=%0d: PRE@A+%0d ready@A+%0d, required A+%0d A+%0d", op, pre_o - a, rdy_o - a, e_pre - a, e_rdy - a); end
      checks++;
      if (op[0] ? (odt_first != e_col || odt_cnt != WL + F_BC) : (odt_cnt != 0))
        begin errors++; $display("FAIL fast_odt op=%0d: first@A+%0d len=%0d, required A+%0d len %0d", op, odt_first - a, odt_cnt, e_col - a, op[0] ? WL + F_BC : 0); end
    end
  endtask

  initial begin
    req_valid = 1'b0; req_wr = 1'b0; req_ba = '0; req_row = '0; req_col = '0;
    f_valid = 1'b0; f_wr = 1'b0; f_ba = '0; f_row = '0; f_col = '0;
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    req_valid = 1'b0;
    test_random();
    test_rst_mid();
    test_fast_build();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
